// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM encodings, the
// divide-by-zero quotient and the iteration-counter width helper.
package div_pkg;

    localparam int DIV_MAX_W = 32;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [DIV_MAX_W-1:0] DIV0_QUOTIENT = '1;

    // Counter must hold the value WIDTH, hence WIDTH+1 states.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Start/done handshake and operand/result bus between the controlling logic
// and the restoring divider.
interface div_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_rca_sub.sv
// Ripple-borrow subtractor built from full-subtractor cells; combinational.
module rca_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);
    logic [W:0] w_bor;

    assign w_bor[0] = 1'b0;

    for (genvar g = 0; g < W; g++) begin : g_fs
        assign o_diff[g]    = i_a[g] ^ i_b[g] ^ w_bor[g];
        assign w_bor[g+1]   = (~i_a[g] & i_b[g]) | (~i_a[g] & w_bor[g]) | (i_b[g] & w_bor[g]);
    end

    assign o_borrow = w_bor[W];
endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results
// registered and flagged with a one-cycle done pulse.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic   clk,
    input logic   rst,
    div_if.slave  bus
);
    localparam int DIV_CNT_W = div_cnt_w(WIDTH);

    logic [1:0]           r_state;
    logic [DIV_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_d;
    logic [WIDTH:0]       r_r;
    logic                 r_done;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_div_by_zero;

    logic [WIDTH:0]       w_rs;
    logic [WIDTH:0]       w_diff;
    logic                 w_borrow;
    logic                 w_unused_r_msb;

    // The partial remainder stays below D, so its top bit is always zero
    // before the shift and never reaches the shifted operand.
    assign w_rs           = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_unused_r_msb = r_r[WIDTH];

    rca_sub #(
        .W (WIDTH + 1)
    ) u_sub (
        .i_a      (w_rs),
        .i_b      ({1'b0, r_d}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_q           <= '0;
            r_d           <= '0;
            r_r           <= '0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            r_q     <= bus.dividend;
                            r_d     <= bus.divisor;
                            r_r     <= '0;
                            r_count <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
                            r_remainder   <= bus.dividend;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Borrow means the trial subtraction failed: restore.
                    r_r     <= w_borrow ? w_rs : w_diff;
                    r_q     <= {r_q[WIDTH-2:0], ~w_borrow};
                    r_count <= r_count + DIV_CNT_W'(1);
                    if (r_count == DIV_CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_quotient    <= r_q;
                    r_remainder   <= r_r[WIDTH-1:0];
                    r_div_by_zero <= 1'b0;
                    r_done        <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random scoreboard bench for the restoring divider.
module tb_restoring_divider;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    div_if #(.WIDTH(WIDTH)) bus ();

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                check("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_quotient", 32'(bus.quotient), 32'(e.q));
                    check("sb_remainder", 32'(bus.remainder), 32'(e.r));
                    check("sb_div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
                    check("sb_busy_at_done", 32'(bus.busy), 32'd0);
                end
            end
        end
    end

    // Drives one request across an edge; caller positions it before the edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
    endtask

    task automatic wait_done(input string tag, input int n0, input int exp_n, output int busy_cnt);
        int n;
        n        = n0;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_n));
    endtask

    function automatic logic [WIDTH-1:0] pick();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return WIDTH'(1);
        if (sel == 2) return '1;
        return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    endfunction

    initial begin
        int bc;
        logic [WIDTH-1:0] a, b;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 200/7 with busy window
        @(negedge clk);
        issue(8'd200, 8'd7, 1'b1);
        check("b1_busy_after_accept", 32'(bus.busy), 32'd1);
        wait_done("b1", 0, WIDTH + 1, bc);
        check("b1_busy_cycles", 32'(bc), 32'(WIDTH));
        check("b1_quotient", 32'(bus.quotient), 32'd28);
        check("b1_remainder", 32'(bus.remainder), 32'd4);

        // 255/1 then 5/9 started in the done cycle
        @(negedge clk);
        issue(8'd255, 8'd1, 1'b1);
        wait_done("b2a", 0, WIDTH + 1, bc);
        check("b2a_quotient", 32'(bus.quotient), 32'd255);
        issue(8'd5, 8'd9, 1'b1);
        check("b2_done_one_cycle", 32'(bus.done), 32'd0);
        check("b2b_busy_no_gap", 32'(bus.busy), 32'd1);
        wait_done("b2b", 0, WIDTH + 1, bc);
        check("b2b_quotient", 32'(bus.quotient), 32'd0);
        check("b2b_remainder", 32'(bus.remainder), 32'd5);
        @(posedge clk);
        #1;
        check("b2b_done_one_cycle", 32'(bus.done), 32'd0);

        // 100/0
        @(negedge clk);
        issue(8'd100, 8'd0, 1'b1);
        check("dz_done", 32'(bus.done), 32'd1);
        check("dz_busy", 32'(bus.busy), 32'd0);
        check("dz_quotient", 32'(bus.quotient), 32'd255);
        check("dz_remainder", 32'(bus.remainder), 32'd100);
        check("dz_flag", 32'(bus.div_by_zero), 32'd1);
        @(posedge clk);
        #1;
        check("dz_done_drop", 32'(bus.done), 32'd0);
        check("dz_busy_after", 32'(bus.busy), 32'd0);

        // start while busy is ignored
        @(negedge clk);
        issue(8'd200, 8'd7, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ign", 3, WIDTH + 1, bc);
        check("ign_quotient", 32'(bus.quotient), 32'd28);
        check("ign_remainder", 32'(bus.remainder), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("ign_no_extra_busy", 32'(bus.busy), 32'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        issue(8'd200, 8'd7, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_quotient", 32'(bus.quotient), 32'd0);
        check("arst_remainder", 32'(bus.remainder), 32'd0);
        check("arst_dz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("arst_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        issue(8'd0, 8'd5, 1'b1);
        wait_done("post_rst", 0, WIDTH + 1, bc);
        check("post_rst_quotient", 32'(bus.quotient), 32'd0);
        check("post_rst_remainder", 32'(bus.remainder), 32'd0);

        // random sweep
        for (int i = 0; i < 2000; i++) begin
            a = pick();
            b = pick();
            @(negedge clk);
            issue(a, b, 1'b1);
            if (b == 0) begin
                check("rnd_dz_done", 32'(bus.done), 32'd1);
                check("rnd_dz_quotient", 32'(bus.quotient), 32'd255);
                check("rnd_dz_remainder", 32'(bus.remainder), 32'(a));
                check("rnd_dz_flag", 32'(bus.div_by_zero), 32'd1);
            end else begin
                wait_done("rnd", 0, WIDTH + 1, bc);
                check("rnd_invariant", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
                check("rnd_rem_lt_div", 32'(bus.remainder < b), 32'd1);
                check("rnd_dz_clear", 32'(bus.div_by_zero), 32'd0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
